hack_cpu_ctrl: RTL and testbench

- Control and register stage of the 16-bit Hack-style CPU. Sits directly around the ALU: it feeds the ALU operands and the 6-bit control field, and consumes the ALU result and the zr/ng flags.
- Holds A, D and PC. Decodes A- and C-instructions, sequences data-memory read/write handshakes, writes results back, and resolves jumps.
- Multi-cycle FSM with a valid/ready instruction fetch interface.

---
 rtl/hack_cpu_ctrl_if.sv | 47 ++++
 rtl/hack_cpu_ctrl.sv | 140 ++++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_cpu_ctrl_if.sv
// Hack CPU control-stage bus: instruction fetch, ALU operands/result, data memory.
interface hack_cpu_ctrl_if #(
  parameter int unsigned PC_WIDTH   = 15,
  parameter int unsigned ADDR_WIDTH = 15
);
  // Instruction fetch handshake
  logic [15:0]           instr;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [PC_WIDTH-1:0]   pc;

  // ALU operands and result
  logic [15:0]           alu_x;
  logic [15:0]           alu_y;
  logic [5:0]            alu_ctrl;
  logic [15:0]           alu_out;
  logic                  alu_zr;
  logic                  alu_ng;

  // Data memory request/ack
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic                  mem_re;
  logic                  mem_we;
  logic [15:0]           mem_rdata;
  logic                  mem_ack;

  // Control stage side
  modport master (
    input  instr, instr_valid,
    output instr_ready, pc,
    output alu_x, alu_y, alu_ctrl,
    input  alu_out, alu_zr, alu_ng,
    output mem_addr, mem_wdata, mem_re, mem_we,
    input  mem_rdata, mem_ack
  );

  // Environment side: instruction source, ALU and data memory
  modport slave (
    output instr, instr_valid,
    input  instr_ready, pc,
    input  alu_x, alu_y, alu_ctrl,
    output alu_out, alu_zr, alu_ng,
    input  mem_addr, mem_wdata, mem_re, mem_we,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/register stage: holds A, D, M_reg, IR and PC, sequences
// fetch, decode, data-memory read, execute and data-memory write.
module hack_cpu_ctrl #(
  parameter int unsigned         PC_WIDTH     = 15,
  parameter int unsigned         ADDR_WIDTH   = 15,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  hack_cpu_ctrl_if.master     bus,
  output logic [15:0]         a_reg,
  output logic [15:0]         d_reg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM_RD = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM_WR = 3'd4
  } state_t;

  state_t                state_q;
  logic [15:0]           a_q;
  logic [15:0]           d_q;
  logic [15:0]           m_q;
  logic [15:0]           ir_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic                  ready_q;
  logic                  mem_re_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [15:0]           mem_wdata_q;

  logic                  jump_c;
  logic [PC_WIDTH-1:0]   pc_inc_c;

  // Jump condition from the ALU flags of the current computation
  assign jump_c   = (ir_q[2] & bus.alu_ng) |
                    (ir_q[1] & bus.alu_zr) |
                    (ir_q[0] & ~bus.alu_ng & ~bus.alu_zr);
  assign pc_inc_c = pc_q + PC_WIDTH'(1);

  // ALU operand/control drive straight from the architectural registers
  assign bus.alu_x    = d_q;
  assign bus.alu_y    = ir_q[12] ? m_q : a_q;
  assign bus.alu_ctrl = ir_q[11:6];

  assign bus.instr_ready = ready_q;
  assign bus.pc          = pc_q;
  assign bus.mem_re      = mem_re_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign a_reg           = a_q;
  assign d_reg           = d_q;

  // Control FSM and register file; A/D reads in EXEC see pre-edge values
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      a_q         <= '0;
      d_q         <= '0;
      m_q         <= '0;
      ir_q        <= '0;
      pc_q        <= RESET_VECTOR;
      ready_q     <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.instr_valid && ready_q) begin
            ir_q    <= bus.instr;
            ready_q <= 1'b0;
            state_q <= S_DECODE;
          end else begin
            ready_q <= 1'b1;
          end
        end

        S_DECODE: begin
          if (!ir_q[15]) begin
            a_q     <= {1'b0, ir_q[14:0]};
            pc_q    <= pc_inc_c;
            ready_q <= 1'b1;
            state_q <= S_FETCH;
          end else if (ir_q[12]) begin
            mem_re_q   <= 1'b1;
            mem_addr_q <= a_q[ADDR_WIDTH-1:0];
            state_q    <= S_MEM_RD;
          end else begin
            state_q <= S_EXEC;
          end
        end

        S_MEM_RD: begin
          if (bus.mem_ack) begin
            m_q      <= bus.mem_rdata;
            mem_re_q <= 1'b0;
            state_q  <= S_EXEC;
          end
        end

        S_EXEC: begin
          pc_q <= jump_c ? a_q[PC_WIDTH-1:0] : pc_inc_c;
          if (ir_q[5]) a_q <= bus.alu_out;
          if (ir_q[4]) d_q <= bus.alu_out;
          if (ir_q[3]) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= a_q[ADDR_WIDTH-1:0];
            mem_wdata_q <= bus.alu_out;
            state_q     <= S_MEM_WR;
          end else begin
            ready_q <= 1'b1;
            state_q <= S_FETCH;
          end
        end

        S_MEM_WR: begin
          if (bus.mem_ack) begin
            mem_we_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= S_FETCH;
          end
        end

        default: begin
          mem_re_q <= 1'b0;
          mem_we_q <= 1'b0;
          ready_q  <= 1'b0;
          state_q  <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Scoreboard bench for hack_cpu_ctrl: directed instructions, ALU and memory models.
module tb_hack_cpu_ctrl;

  localparam int unsigned PW = 15;
  localparam int unsigned AW = 15;
  localparam int unsigned TMO = 60;

  typedef struct {
    logic [15:0]   a;
    logic [15:0]   d;
    logic [PW-1:0] pc;
    logic [5:0]    ctrl;
    int unsigned   lat;
  } st_exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    int unsigned   len;   // 0: request is aborted, length not checked
  } mem_exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_reg;
  logic [15:0] d_reg;

  int n_chk;
  int n_fail;

  int unsigned wait_cycles;
  logic [15:0] rd_val;

  st_exp_t  st_q[$];
  mem_exp_t mem_q[$];

  hack_cpu_ctrl_if #(.PC_WIDTH(PW), .ADDR_WIDTH(AW)) bus();

  hack_cpu_ctrl #(.PC_WIDTH(PW), .ADDR_WIDTH(AW), .RESET_VECTOR('0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .a_reg (a_reg),
    .d_reg (d_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Hack ALU
  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  always_comb begin
    logic [15:0] r;
    r = hack_alu(bus.alu_x, bus.alu_y, bus.alu_ctrl);
    bus.alu_out = r;
    bus.alu_zr  = (r == 16'h0000);
    bus.alu_ng  = r[15];
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no response within %0d cycles (t=%0t)", name, TMO, $time);
  endtask

  // Data memory responder: ack after wait_cycles extra cycles of a request
  initial begin
    int unsigned cnt;
    cnt = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      bus.mem_rdata = rd_val;
      if (bus.mem_re === 1'b1 || bus.mem_we === 1'b1) begin
        bus.mem_ack = (cnt == wait_cycles);
        cnt++;
      end else begin
        bus.mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: pops expected memory requests and completed-instruction state
  initial begin
    bit            inflight;
    int unsigned   lat;
    bit            req_active;
    int unsigned   req_len;
    mem_exp_t      me;
    st_exp_t       se;
    logic          strobe;
    inflight   = 0;
    lat        = 0;
    req_active = 0;
    req_len    = 0;
    me         = '{we: 1'b0, addr: '0, wdata: '0, len: 0};
    forever begin
      @(negedge clk);
      strobe = (bus.mem_re === 1'b1) || (bus.mem_we === 1'b1);
      if (bus.mem_re === 1'b1 && bus.mem_we === 1'b1)
        chk("re_we_exclusive", 16'h0001, 16'h0000);

      if (strobe && !req_active) begin
        req_active = 1;
        req_len    = 0;
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_req", 16'(bus.mem_addr), 16'hFFFF);
        end else begin
          me = mem_q.pop_front();
          chk("mem_kind_we", 16'(bus.mem_we), 16'(me.we));
          chk("mem_addr", 16'(bus.mem_addr), 16'(me.addr));
          if (me.we) chk("mem_wdata", bus.mem_wdata, me.wdata);
        end
      end
      if (strobe && req_active) begin
        req_len++;
        if (req_len > 1) begin
          chk("mem_addr_stable", 16'(bus.mem_addr), 16'(me.addr));
          if (me.we) chk("mem_wdata_stable", bus.mem_wdata, me.wdata);
        end
      end
      if (!strobe && req_active) begin
        req_active = 0;
        if (me.len != 0) chk("mem_req_cycles", 16'(req_len), 16'(me.len));
      end

      if (rst_n !== 1'b1) begin
        inflight = 0;
      end else begin
        if (inflight) begin
          lat++;
          if (bus.instr_ready === 1'b1) begin
            inflight = 0;
            if (st_q.size() == 0) begin
              chk("unexpected_completion", a_reg, 16'hFFFF);
            end else begin
              se = st_q.pop_front();
              chk("a_reg", a_reg, se.a);
              chk("d_reg", d_reg, se.d);
              chk("pc", 16'(bus.pc), 16'(se.pc));
              chk("alu_ctrl", 16'(bus.alu_ctrl), 16'(se.ctrl));
              chk("latency", 16'(lat), 16'(se.lat));
            end
          end
        end
        if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
          inflight = 1;
          lat      = 0;
        end
      end
    end
  end

  task automatic push_mem(input logic we, input logic [AW-1:0] addr, input logic [15:0] wdata,
                          input int unsigned len);
    mem_q.push_back('{we: we, addr: addr, wdata: wdata, len: len});
  endtask

  task automatic send(input logic [15:0] ins, input int unsigned wt, input logic [15:0] rd);
    int unsigned n;
    logic [15:0] iv;
    iv = ins;
    wait_cycles = wt;
    rd_val      = rd;
    @(posedge clk); #1;
    bus.instr       = iv;
    bus.instr_valid = 1'b1;
    n = 0;
    while (bus.instr_ready !== 1'b1 && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= TMO) timeout("instr_accept");
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int unsigned n;
    n = 0;
    while (bus.instr_ready !== 1'b1 && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= TMO) timeout(name);
  endtask

  task automatic run(input logic [15:0] ins, input int unsigned wt, input logic [15:0] rd,
                     input logic [15:0] ea, input logic [15:0] ed, input logic [PW-1:0] epc,
                     input int unsigned elat);
    logic [15:0] iv;
    iv = ins;
    st_q.push_back('{a: ea, d: ed, pc: epc, ctrl: iv[11:6], lat: elat});
    send(ins, wt, rd);
    wait_ready("instr_complete");
    @(negedge clk);
  endtask

  // Directed stimulus
  initial begin
    int unsigned n;
    n_chk           = 0;
    n_fail          = 0;
    wait_cycles     = 0;
    rd_val          = 16'h0000;
    rst_n           = 1'b0;
    bus.instr       = 16'h0000;
    bus.instr_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr_ready", 16'(bus.instr_ready), 16'h0000);
    chk("rst_pc", 16'(bus.pc), 16'h0000);
    chk("rst_a", a_reg, 16'h0000);
    chk("rst_d", d_reg, 16'h0000);
    chk("rst_mem_re", 16'(bus.mem_re), 16'h0000);
    chk("rst_mem_we", 16'(bus.mem_we), 16'h0000);
    chk("rst_mem_addr", 16'(bus.mem_addr), 16'h0000);
    chk("rst_mem_wdata", bus.mem_wdata, 16'h0000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 16'(bus.instr_ready), 16'h0001);

    //   instr    wt rdata     A        D        PC       lat
    run(16'h0005, 0, 16'h0, 16'h0005, 16'h0000, 15'h0001, 2);   // @5
    run(16'hEC10, 0, 16'h0, 16'h0005, 16'h0005, 15'h0002, 3);   // D=A
    run(16'h0007, 0, 16'h0, 16'h0007, 16'h0005, 15'h0003, 2);   // @7
    run(16'hEC10, 0, 16'h0, 16'h0007, 16'h0007, 15'h0004, 3);   // D=A
    run(16'h0064, 0, 16'h0, 16'h0064, 16'h0007, 15'h0005, 2);   // @100
    push_mem(1'b1, 15'd100, 16'h0008, 4);
    run(16'hE7C8, 3, 16'h0, 16'h0064, 16'h0007, 15'h0006, 7);   // M=D+1, 3 wait cycles
    push_mem(1'b0, 15'd100, 16'h0000, 2);
    run(16'hFC10, 1, 16'h1234, 16'h0064, 16'h1234, 15'h0007, 5); // D=M, ack on 2nd cycle
    run(16'h0014, 0, 16'h0, 16'h0014, 16'h1234, 15'h0008, 2);   // @20
    run(16'hEE90, 0, 16'h0, 16'h0014, 16'hFFFF, 15'h0009, 3);   // D=-1
    run(16'hE304, 0, 16'h0, 16'h0014, 16'hFFFF, 15'h0014, 3);   // D;JLT taken
    run(16'hEA90, 0, 16'h0, 16'h0014, 16'h0000, 15'h0015, 3);   // D=0
    run(16'hE304, 0, 16'h0, 16'h0014, 16'h0000, 15'h0016, 3);   // D;JLT not taken
    run(16'h0033, 0, 16'h0, 16'h0033, 16'h0000, 15'h0017, 2);   // @0x33
    run(16'hEC10, 0, 16'h0, 16'h0033, 16'h0033, 15'h0018, 3);   // D=A
    run(16'h001E, 0, 16'h0, 16'h001E, 16'h0033, 15'h0019, 2);   // @30
    push_mem(1'b1, 15'd30, 16'h0033, 1);
    run(16'hE32F, 0, 16'h0, 16'h0033, 16'h0033, 15'h001E, 4);   // AM=D;JMP uses old A
    run(16'h7FFF, 0, 16'h0, 16'h7FFF, 16'h0033, 15'h001F, 2);   // @0x7FFF
    run(16'hEA87, 0, 16'h0, 16'h7FFF, 16'h0033, 15'h7FFF, 3);   // 0;JMP
    run(16'h0003, 0, 16'h0, 16'h0003, 16'h0033, 15'h0000, 2);   // @3, pc wraps

    // Reset in the middle of a stalled M write
    push_mem(1'b1, 15'd3, 16'h0033, 0);
    send(16'hE308, 10, 16'h0);                                   // M=D
    n = 0;
    while (bus.mem_we !== 1'b1 && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= TMO) timeout("mem_we_start");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_mem_we", 16'(bus.mem_we), 16'h0000);
    chk("midrst_mem_re", 16'(bus.mem_re), 16'h0000);
    chk("midrst_pc", 16'(bus.pc), 16'h0000);
    chk("midrst_a", a_reg, 16'h0000);
    chk("midrst_d", d_reg, 16'h0000);
    chk("midrst_ready", 16'(bus.instr_ready), 16'h0000);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_ready", 16'(bus.instr_ready), 16'h0001);
    chk("sb_state_left", 16'(st_q.size()), 16'h0000);
    chk("sb_mem_left", 16'(mem_q.size()), 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
